// File: rtl/aes_byte_framer.sv
// aes_byte_framer: byte-serial load/unload wrapper around a fixed-latency AES-128 core
module aes_byte_framer #(
  parameter int LATENCY = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic         key_reuse,
  output logic [127:0] aes_datain,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_dataout,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done
);
  localparam int WW = $clog2(LATENCY + 1);
  localparam logic [1:0] LOAD_DATA = 2'd0;
  localparam logic [1:0] LOAD_KEY  = 2'd1;
  localparam logic [1:0] WAIT      = 2'd2;
  localparam logic [1:0] SEND      = 2'd3;
  localparam logic [WW-1:0] WAIT_INIT = WW'(LATENCY - 1);
  logic [1:0]    state;
  logic [3:0]    byte_cnt;
  logic [3:0]    lane;
  logic [WW-1:0] wait_cnt;
  logic [127:0]  result;
  logic          rx_fire;
  logic          tx_fire;
  logic          last;
  logic          capture;
  assign rx_ready = state == LOAD_DATA || state == LOAD_KEY;
  assign busy     = state != LOAD_DATA;
  assign tx_valid = state == SEND;
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign last     = byte_cnt == 4'd15;
  assign capture  = state == WAIT && wait_cnt == '0;
  // byte k of a block lives in lane 15-k, so the MSB byte goes first
  assign lane     = ~byte_cnt;
  assign tx_data  = result[{lane, 3'b000} +: 8];
  // sequencing: load data, optionally load key, count down the core latency, stream the result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= LOAD_DATA;
      byte_cnt <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done     <= tx_fire && last;
      byte_cnt <= (rx_fire || tx_fire) ? byte_cnt + 4'd1 : byte_cnt;
      wait_cnt <= (rx_fire && last) ? WAIT_INIT : (state == WAIT && wait_cnt != '0) ? wait_cnt - WW'(1) : wait_cnt;
      case (state)
        LOAD_DATA: if (rx_fire && last) state <= key_reuse ? WAIT : LOAD_KEY;
        LOAD_KEY:  if (rx_fire && last) state <= WAIT;
        WAIT:      if (capture) state <= SEND;
        default:   if (tx_fire && last) state <= LOAD_DATA;
      endcase
    end
  // datapath: shift bytes into plaintext/key registers and capture the ciphertext once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aes_datain <= '0;
      aes_key    <= '0;
      result     <= '0;
    end else begin
      if (rx_fire && state == LOAD_DATA) aes_datain[{lane, 3'b000} +: 8] <= rx_data;
      if (rx_fire && state == LOAD_KEY) aes_key[{lane, 3'b000} +: 8] <= rx_data;
      if (capture) result <= aes_dataout;
    end
endmodule

// File: tb/tb_aes_byte_framer.sv
// tb_aes_byte_framer: two framers (latency 10 and 1) sharing one random byte stream, checked against a frame-level model
module tb_aes_byte_framer;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        key_reuse = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] cyc = 32'd0;
  logic [1:0]  rdy;
  logic [1:0]  bsy;
  int          txc0 = 0;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  // free-running cycle stamp; the core stub output depends on it so capture timing is visible
  always @(posedge clk) cyc <= cyc + 32'd1;
  // core stub: the real FIPS-197 answer for the known vector, otherwise a cycle-varying mix
  function automatic logic [127:0] core(input logic [127:0] d, input logic [127:0] k, input logic [31:0] c);
    return (d == FIPS_PT && k == FIPS_KEY) ? FIPS_CT : d ^ {k[63:0], k[127:64]} ^ {4{c}};
  endfunction
  task automatic check(input string nm, input logic [259:0] act, input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  genvar g;
  for (g = 0; g < 2; g++) begin : inst
    localparam int LAT = g == 0 ? 10 : 1;
    logic         rx_ready, busy, tx_valid, done;
    logic [127:0] aes_datain, aes_key, aes_dataout;
    logic [7:0]   tx_data;
    aes_byte_framer #(.LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .key_reuse(key_reuse), .aes_datain(aes_datain), .aes_key(aes_key), .aes_dataout(aes_dataout),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );
    assign aes_dataout = core(aes_datain, aes_key, cyc);
    assign rdy[g] = rx_ready;
    assign bsy[g] = busy;
    // model: n_in counts accepted bytes (0-15 data, 16-31 key), t_cap is the cycle stamp of capture
    int           n_in = 0, n_out = 0, t_cap = -1, dcnt = 0;
    bit           cap = 1'b0, m_done = 1'b0;
    logic [127:0] m_pt = '0, m_key = '0, m_res = '0, got = '0;
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        n_in <= 0; n_out <= 0; t_cap <= -1; cap <= 1'b0; m_done <= 1'b0;
        m_pt <= '0; m_key <= '0; m_res <= '0;
      end else begin
        m_done <= 1'b0;
        if (t_cap < 0) begin
          if (rx_valid) begin
            if (n_in < 16) m_pt[127-8*n_in -: 8] <= rx_data;
            else m_key[255-8*n_in -: 8] <= rx_data;
            if ((n_in == 15 && key_reuse) || n_in == 31) begin
              n_in <= 0;
              t_cap <= int'(cyc) + LAT;
            end else n_in <= n_in + 1;
          end
        end else if (!cap) begin
          if (int'(cyc) == t_cap) begin
            m_res <= core(m_pt, m_key, cyc);
            cap <= 1'b1;
          end
        end else if (tx_ready) begin
          if (n_out == 15) begin
            n_out <= 0; cap <= 1'b0; t_cap <= -1; m_done <= 1'b1;
          end else n_out <= n_out + 1;
        end
      end
    // collect what actually left the DUT for the literal frame checks
    always @(posedge clk) begin
      if (tx_valid && tx_ready) got <= {got[119:0], tx_data};
      if (done) dcnt <= dcnt + 1;
    end
    always @(negedge clk) begin
      check($sformatf("ctl%0d", g), {rx_ready, busy, tx_valid, done, aes_datain, aes_key},
            {t_cap < 0, !(t_cap < 0 && n_in < 16), cap, m_done, m_pt, m_key});
      if (cap) check($sformatf("txd%0d", g), 260'(tx_data), 260'(m_res[127-8*n_out -: 8]));
    end
  end
  always @(posedge clk) if (inst[0].tx_valid && tx_ready) txc0 <= txc0 + 1;
  // downstream accepts roughly 30% of cycles
  initial forever begin
    @(negedge clk);
    tx_ready = $urandom_range(0, 9) < 3;
  end
  task automatic check_rst(input string nm);
    check({nm, "0"}, {inst[0].rx_ready, inst[0].busy, inst[0].tx_valid, inst[0].done, inst[0].aes_datain, inst[0].aes_key}, {4'b1000, 256'd0});
    check({nm, "1"}, {inst[1].rx_ready, inst[1].busy, inst[1].tx_valid, inst[1].done, inst[1].aes_datain, inst[1].aes_key}, {4'b1000, 256'd0});
  endtask
  task automatic send_byte(input logic [7:0] b, input logic kr);
    while ($urandom_range(0, 9) < 3) begin
      rx_valid = 1'b0; rx_data = 8'($urandom); key_reuse = 1'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1; rx_data = b; key_reuse = kr;
    @(negedge clk);
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 600 && bsy != 2'b00; n++) begin
      if (bsy != 2'b11) rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("idle_timeout", 260'(bsy), 260'(0));
    @(negedge clk);
  endtask
  task automatic frame(input logic [127:0] pt, input logic [127:0] k, input logic reuse, input logic aa, output logic [31:0] c_last);
    for (int i = 0; i < 16; i++) send_byte(pt[127-8*i -: 8], i == 15 ? reuse : 1'($urandom));
    if (!reuse) for (int i = 0; i < 16; i++) send_byte(k[127-8*i -: 8], 1'($urandom));
    c_last = cyc - 32'd1;
    check("rx_ready_drop", 260'(rdy), 260'(0));
    rx_valid = aa; rx_data = 8'hAA;
    wait_idle();
  endtask
  initial begin
    logic [31:0]  c;
    logic [127:0] pt;
    int           d0, d1, s;
    repeat (2) @(negedge clk);
    check_rst("reset");
    rst_n = 1'b1;
    @(negedge clk);
    d0 = inst[0].dcnt; d1 = inst[1].dcnt;
    frame(FIPS_PT, FIPS_KEY, 1'b0, 1'b0, c);
    check("fips0", 260'(inst[0].got), 260'(FIPS_CT));
    check("fips1", 260'(inst[1].got), 260'(FIPS_CT));
    check("done_once0", 260'(inst[0].dcnt - d0), 260'(1));
    check("done_once1", 260'(inst[1].dcnt - d1), 260'(1));
    frame(FIPS_PT, 128'h0, 1'b1, 1'b1, c);
    check("reuse0", 260'(inst[0].got), 260'(FIPS_CT));
    check("reuse1", 260'(inst[1].got), 260'(FIPS_CT));
    frame(128'h0, 128'h0, 1'b0, 1'b1, c);
    check("lat10", 260'(inst[0].got), 260'({4{c + 32'd10}}));
    check("lat1", 260'(inst[1].got), 260'({4{c + 32'd1}}));
    for (int f = 0; f < 8; f++) begin
      frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom), c);
    end
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), i == 15 ? 1'b0 : 1'($urandom));
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'($urandom));
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_rst("rst_key");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b0);
    rx_valid = 1'b0;
    s = txc0;
    for (int n = 0; n < 600 && txc0 < s + 3; n++) @(negedge clk);
    check("tx3_timeout", 260'(txc0 >= s + 3), 260'(1));
    #2 rst_n = 1'b0;
    #1 check_rst("rst_send");
    @(negedge clk);
    rst_n = 1'b1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    frame(pt, 128'h0, 1'b1, 1'b0, c);
    check("zero_key0", 260'(inst[0].got), 260'(pt ^ {4{c + 32'd10}}));
    check("zero_key1", 260'(inst[1].got), 260'(pt ^ {4{c + 32'd1}}));
    frame(FIPS_PT, FIPS_KEY, 1'b0, 1'b1, c);
    check("post_rst0", 260'(inst[0].got), 260'(FIPS_CT));
    check("post_rst1", 260'(inst[1].got), 260'(FIPS_CT));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
